// File: rtl/cdr_strobe_sequencer_pkg.sv
// Shared types and helpers for the CDR strobe sequencer.
package cdr_pkg;

   localparam int CNT_W_DEF      = 6;
   localparam int N_SMP_DEF      = 3;
   localparam int MIN_PERIOD_DEF = 8;

   typedef logic [CNT_W_DEF-1:0] cnt_t;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } seq_state_e;

   // Pending phase nudge held for the current or the next period.
   typedef enum logic [1:0] {
      ADJ_NONE = 2'd0,
      ADJ_ADV  = 2'd1,
      ADJ_RET  = 2'd2
   } adj_e;

   // Requested periods below the legal minimum are raised to the minimum.
   function automatic int unsigned clamp_period(input int unsigned p, input int unsigned min_p);
      return (p < min_p) ? min_p : p;
   endfunction

endpackage

// File: rtl/cdr_strobe_sequencer_if.sv
// Control/strobe bundle between the loop filter side and the strobe sequencer.
interface cdr_strobe_sequencer_if
   import cdr_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int N_SMP = N_SMP_DEF
);
   logic                   i_en;
   logic [CNT_W-1:0]       i_nb_p;
   logic [N_SMP*CNT_W-1:0] i_smp_off;
   logic                   i_adv;
   logic                   i_ret;
   logic [CNT_W-1:0]       o_cnt;
   logic [N_SMP-1:0]       o_smp_en;
   logic                   o_en_pd;
   logic                   o_en_fs;
   logic                   o_wrap;
   logic                   o_period_err;
   logic                   o_adj_drop;

   modport master (
      output i_en, i_nb_p, i_smp_off, i_adv, i_ret,
      input  o_cnt, o_smp_en, o_en_pd, o_en_fs, o_wrap, o_period_err, o_adj_drop
   );

   modport slave (
      input  i_en, i_nb_p, i_smp_off, i_adv, i_ret,
      output o_cnt, o_smp_en, o_en_pd, o_en_fs, o_wrap, o_period_err, o_adj_drop
   );
endinterface

// File: rtl/cdr_strobe_sequencer_offset_match.sv
// One sample-strobe channel: shadowed offset plus a registered count compare.
// The compare uses the next count so the strobe lands in the cycle where o_cnt equals the offset.
module cdr_offset_match
   import cdr_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic             i_active,
   input  logic [CNT_W-1:0] i_cnt_nxt,
   input  logic [CNT_W-1:0] i_off,
   output logic             o_hit
);

   logic [CNT_W-1:0] off_q, off_d;
   logic             hit_q, hit_d;

   // On a load the new offset already governs the first count of the new period.
   always_comb begin
      off_d = i_load ? i_off : off_q;
      hit_d = i_active && (i_cnt_nxt == off_d);
   end

   // Shadow offset and strobe register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         off_q <= '0;
         hit_q <= 1'b0;
      end else begin
         off_q <= off_d;
         hit_q <= hit_d;
      end
   end

   assign o_hit = hit_q;

endmodule

// File: rtl/cdr_strobe_sequencer.sv
// Programmable-period phase counter for the CDR loop with per-channel sample strobes,
// phase-detector / frequency-sync strobes and one-per-period phase nudges.
//
//   state | meaning
//   IDLE  | disabled, counter held at 0, no strobes
//   RUN   | counting 0..T, strobes decoded from the next count
module cdr_strobe_sequencer
   import cdr_pkg::*;
#(
   parameter int CNT_W      = CNT_W_DEF,
   parameter int N_SMP      = N_SMP_DEF,
   parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   cdr_strobe_sequencer_if.slave  bus
);

   localparam logic [CNT_W-1:0] TC_MIN = CNT_W'(MIN_PERIOD - 1);
   localparam logic [CNT_W-1:0] TC_MAX = '1;

   seq_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] base_q, base_d;   // Ps-1 of the current period
   logic [CNT_W-1:0] tc_q, tc_d;       // effective terminal count
   adj_e             adj_q, adj_d;
   logic             act_q, act_d;     // pending nudge already applied to this period
   logic             err_q, err_d;
   logic             drop_q, drop_d;
   logic             wrap_q, wrap_d;
   logic             pd_q, pd_d;
   logic             fs_q, fs_d;
   logic             run_d, load, wrap_now, req;
   adj_e             req_dir;
   logic [CNT_W-1:0] nb_clamped;
   logic             nb_below;
   logic [N_SMP-1:0] smp_en;

   assign nb_clamped = CNT_W'(clamp_period(32'(bus.i_nb_p), MIN_PERIOD));
   assign nb_below   = (bus.i_nb_p < CNT_W'(MIN_PERIOD));

   // Next-state: FSM, shadow load, adjustment latch and pd/fs/wrap decode.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      base_d   = base_q;
      adj_d    = adj_q;
      act_d    = act_q;
      err_d    = err_q;
      drop_d   = 1'b0;
      load     = 1'b0;
      run_d    = 1'b0;
      wrap_now = (cnt_q == tc_q);
      req      = bus.i_adv ^ bus.i_ret;
      req_dir  = bus.i_adv ? ADJ_ADV : ADJ_RET;

      case (state_q)
         IDLE: begin
            if (bus.i_en) begin
               state_d = RUN;
               run_d   = 1'b1;
               load    = 1'b1;
               cnt_d   = '0;
               adj_d   = ADJ_NONE;
               act_d   = 1'b0;
            end
         end
         RUN: begin
            if (!bus.i_en) begin
               state_d = IDLE;
               cnt_d   = '0;
               adj_d   = ADJ_NONE;
               act_d   = 1'b0;
            end else begin
               run_d = 1'b1;
               if (wrap_now) begin
                  cnt_d = '0;
                  load  = 1'b1;
                  // An applied nudge expires here; a deferred one takes over the new period.
                  if (adj_q == ADJ_NONE || act_q) begin
                     adj_d = ADJ_NONE;
                     act_d = 1'b0;
                  end else begin
                     act_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
               if (req) begin
                  if (adj_d != ADJ_NONE) begin
                     drop_d = 1'b1;
                  end else begin
                     adj_d = req_dir;
                     // Late requests would skip the pd/fs strobes, so they wait a period.
                     act_d = wrap_now || (cnt_q <= tc_q - CNT_W'(3));
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         base_d = nb_clamped - CNT_W'(1);
         if (nb_below) begin
            err_d = 1'b1;
         end
      end

      // A nudge that would leave the legal terminal-count range is discarded.
      if (act_d && ((adj_d == ADJ_ADV && base_d == TC_MIN) ||
                    (adj_d == ADJ_RET && base_d == TC_MAX))) begin
         drop_d = 1'b1;
         adj_d  = ADJ_NONE;
         act_d  = 1'b0;
      end

      tc_d = base_d;
      if (act_d) begin
         tc_d = (adj_d == ADJ_ADV) ? base_d - CNT_W'(1) : base_d + CNT_W'(1);
      end

      wrap_d = run_d && (cnt_d == tc_d);
      pd_d   = run_d && (cnt_d == tc_d - CNT_W'(2));
      fs_d   = run_d && (cnt_d == tc_d - CNT_W'(1));
   end

   // State, shadows and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         base_q  <= '0;
         tc_q    <= '0;
         adj_q   <= ADJ_NONE;
         act_q   <= 1'b0;
         err_q   <= 1'b0;
         drop_q  <= 1'b0;
         wrap_q  <= 1'b0;
         pd_q    <= 1'b0;
         fs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         tc_q    <= tc_d;
         adj_q   <= adj_d;
         act_q   <= act_d;
         err_q   <= err_d;
         drop_q  <= drop_d;
         wrap_q  <= wrap_d;
         pd_q    <= pd_d;
         fs_q    <= fs_d;
      end
   end

   for (genvar k = 0; k < N_SMP; k++) begin : g_smp
      cdr_offset_match #(.CNT_W(CNT_W)) u_match (
         .i_clk     (i_clk),
         .i_rst     (i_rst),
         .i_load    (load),
         .i_active  (run_d),
         .i_cnt_nxt (cnt_d),
         .i_off     (bus.i_smp_off[k*CNT_W +: CNT_W]),
         .o_hit     (smp_en[k])
      );
   end

   assign bus.o_cnt        = cnt_q;
   assign bus.o_smp_en     = smp_en;
   assign bus.o_en_pd      = pd_q;
   assign bus.o_en_fs      = fs_q;
   assign bus.o_wrap       = wrap_q;
   assign bus.o_period_err = err_q;
   assign bus.o_adj_drop   = drop_q;

endmodule
